// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcode constants, datapath widths and arbiter FSM state encoding.
package alu_pkg;
    localparam int DATA_W = 32;
    localparam int OP_W   = 6;
    localparam logic [OP_W-1:0] OP_ALU_NOP  = 6'd0;
    localparam logic [OP_W-1:0] OP_ALU_ADD  = 6'd1;
    localparam logic [OP_W-1:0] OP_ALU_SUB  = 6'd2;
    localparam logic [OP_W-1:0] OP_ALU_SLL  = 6'd3;
    localparam logic [OP_W-1:0] OP_ALU_SRL  = 6'd4;
    localparam logic [OP_W-1:0] OP_ALU_SRA  = 6'd5;
    localparam logic [OP_W-1:0] OP_ALU_AND  = 6'd6;
    localparam logic [OP_W-1:0] OP_ALU_OR   = 6'd7;
    localparam logic [OP_W-1:0] OP_ALU_XOR  = 6'd8;
    localparam logic [OP_W-1:0] OP_ALU_SLT  = 6'd9;
    localparam logic [OP_W-1:0] OP_ALU_SLTU = 6'd10;
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} arb_state_e;
endpackage

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: picks one valid requester, first at/after ptr_i (round-robin) or lowest index
// when ALU_ARB_FIXED_PRIO_EN is defined (pointer input removed).
module alu_rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
`ifndef ALU_ARB_FIXED_PRIO_EN
    input  logic [IDX_W-1:0] ptr_i,
`endif
    input  logic [N_REQ-1:0] valid_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);
    always_comb begin
        int k;
        k = 0;
        grant_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            k = i;
`else
            k = (int'(ptr_i) + i) % N_REQ;
`endif
            if (!any_o && valid_i[k]) begin
                any_o = 1'b1;
                grant_o[k] = 1'b1;
                idx_o = IDX_W'(k);
            end
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU among N_REQ requesters with an IDLE->EXEC->RESP FSM.
// Define ALU_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int OP_W   = alu_pkg::OP_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req_valid,
    output logic [N_REQ-1:0]        o_req_ready,
    input  logic [N_REQ*OP_W-1:0]   i_req_op,
    input  logic [N_REQ*DATA_W-1:0] i_req_a,
    input  logic [N_REQ*DATA_W-1:0] i_req_b,
    output logic [N_REQ-1:0]        o_rsp_valid,
    input  logic [N_REQ-1:0]        i_rsp_ready,
    output logic [DATA_W-1:0]       o_rsp_data,
    output logic [OP_W-1:0]         o_alu_op,
    output logic [DATA_W-1:0]       o_alu_a,
    output logic [DATA_W-1:0]       o_alu_b,
    input  logic [DATA_W-1:0]       i_alu_c,
    output logic                    o_busy
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    arb_state_e        state_q;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q, b_q, res_q;
    logic [IDX_W-1:0]  owner_q, gnt_idx;
    logic [N_REQ-1:0]  gnt;
    logic              gnt_any;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    assign ptr_d = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
`endif

    alu_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
`ifndef ALU_ARB_FIXED_PRIO_EN
        .ptr_i   (ptr_q),
`endif
        .valid_i (i_req_valid),
        .grant_o (gnt),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    assign o_req_ready = (state_q == ST_IDLE) ? gnt : '0;
    assign o_rsp_valid = (state_q == ST_RESP) ? (N_REQ'(1) << owner_q) : '0;
    assign o_rsp_data  = res_q;
    assign o_alu_op    = op_q;
    assign o_alu_a     = a_q;
    assign o_alu_b     = b_q;
    assign o_busy      = state_q != ST_IDLE;

    // ALU sees only latched operands, so its inputs stay frozen outside EXEC
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ALU_NOP;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            owner_q <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: if (gnt_any) begin
                    op_q    <= i_req_op[gnt_idx*OP_W +: OP_W];
                    a_q     <= i_req_a[gnt_idx*DATA_W +: DATA_W];
                    b_q     <= i_req_b[gnt_idx*DATA_W +: DATA_W];
                    owner_q <= gnt_idx;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    ptr_q   <= ptr_d;
`endif
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_q   <= i_alu_c;
                    state_q <= ST_RESP;
                end
                ST_RESP: if (i_rsp_ready[owner_q]) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter with a small stand-in ALU.
// Expected order follows ALU_ARB_FIXED_PRIO_EN when defined.
module tb_alu_arbiter;
    import alu_pkg::*;
    localparam int N = 2;
    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*OP_W-1:0] req_op;
    logic [N*DATA_W-1:0] req_a, req_b;
    logic [DATA_W-1:0] rsp_data, alu_a, alu_b, alu_c;
    logic [OP_W-1:0] alu_op;
    logic busy;
    int total = 0, bad = 0, cyc = 0;
    typedef struct {int owner; logic [31:0] data;} exp_t;
    exp_t sb[$];
`ifdef ALU_ARB_FIXED_PRIO_EN
    int exp_ord[4] = '{0, 0, 0, 0};
`else
    int exp_ord[4] = '{0, 1, 0, 1};
`endif

    alu_arbiter #(.N_REQ(N)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_op(req_op), .i_req_a(req_a), .i_req_b(req_b),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
        .o_alu_op(alu_op), .o_alu_a(alu_a), .o_alu_b(alu_b), .i_alu_c(alu_c),
        .o_busy(busy)
    );

    always_comb begin
        alu_c = '0;
        case (alu_op)
            OP_ALU_ADD: alu_c = alu_a + alu_b;
            OP_ALU_SUB: alu_c = alu_a - alu_b;
            OP_ALU_SRA: alu_c = $signed(alu_a) >>> alu_b[4:0];
            OP_ALU_NOP: alu_c = {alu_a[15:0], alu_a[31:16]};
            default:    alu_c = '0;
        endcase
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic [OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[k*OP_W +: OP_W] = op;
        req_a[k*32 +: 32] = a;
        req_b[k*32 +: 32] = b;
        req_valid[k] = 1'b1;
        #1;
    endtask

    task automatic wait_ready(input int k, output int t);
        t = -1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready[k]) begin
                t = cyc;
                break;
            end
            tick();
        end
        chk("accept_seen", 32'(t >= 0), 1);
    endtask

    task automatic wait_rsp(input int k, output int t);
        t = -1;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid[k]) begin
                t = cyc;
                break;
            end
            tick();
        end
        chk("rsp_seen", 32'(t >= 0), 1);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_owner"}, 32'(rsp_valid), 32'(1 << e.owner));
            chk({tag, "_data"}, rsp_data, e.data);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 0);
        chk({tag, "_rspv"}, 32'(rsp_valid), 0);
        chk({tag, "_data"}, rsp_data, 0);
        chk({tag, "_op"}, 32'(alu_op), 32'(OP_ALU_NOP));
        chk({tag, "_a"}, alu_a, 0);
        chk({tag, "_b"}, alu_b, 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic run_op(input int k, input logic [OP_W-1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input string tag);
        int t0, t1;
        sb.push_back('{k, exp});
        drive(k, op, a, b);
        wait_ready(k, t0);
        tick();
        req_valid[k] = 1'b0;
        chk({tag, "_exec_op"}, 32'(alu_op), 32'(op));
        chk({tag, "_exec_a"}, alu_a, a);
        chk({tag, "_exec_b"}, alu_b, b);
        wait_rsp(k, t1);
        chk({tag, "_latency"}, t1 - t0, 2);
        pop_check(tag);
    endtask

    initial begin
        int t, n, idx;
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        tick();
        tick();
        chk_reset("rst");
        rst = 1'b0;
        tick();

        run_op(0, OP_ALU_ADD, 32'd5, 32'd3, 32'h8, "add");
        tick();
        chk("add_idle", 32'(busy), 0);

        rst = 1'b1;
        #1;
        rst = 1'b0;
        tick();
        drive(0, OP_ALU_ADD, 32'd1, 32'd2);
        drive(1, OP_ALU_ADD, 32'd10, 32'd20);
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            if (rsp_valid != 0) pop_check("cont");
            if (req_ready != 0) begin
                chk("cont_onehot", $countones(req_ready), 1);
                idx = req_ready[1] ? 1 : 0;
                chk("cont_order", idx, exp_ord[n]);
                sb.push_back('{exp_ord[n], (exp_ord[n] == 1) ? 32'd30 : 32'd3});
                n++;
            end
            tick();
        end
        chk("cont_count", n, 4);
        req_valid = '0;
        wait_rsp(exp_ord[3], t);
        pop_check("cont_last");
        tick();

        rsp_ready = '0;
        run_op(1, OP_ALU_SUB, 32'd10, 32'd3, 32'h7, "sub");
        drive(0, OP_ALU_ADD, 32'd1, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(rsp_valid), 32'b10);
            chk("bp_data", rsp_data, 32'h7);
            chk("bp_noaccept", 32'(req_ready), 0);
        end
        req_valid = '0;
        rsp_ready = 2'b10;
        tick();
        chk("bp_release", 32'(busy), 0);

        run_op(0, OP_ALU_ADD, 32'd7, 32'd8, 32'd15, "wr");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wr_held", 32'(rsp_valid), 32'b01);
            chk("wr_busy", 32'(busy), 1);
        end
        rsp_ready = 2'b01;
        tick();
        chk("wr_release", 32'(busy), 0);

        rsp_ready = '1;
        drive(0, OP_ALU_ADD, 32'd2, 32'd2);
        wait_ready(0, t);
        tick();
        req_valid = '0;
        chk("rex_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk_reset("rex");
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rex_no_rsp", 32'(rsp_valid), 0);
        end
        drive(0, OP_ALU_ADD, 32'd4, 32'd4);
        drive(1, OP_ALU_ADD, 32'd9, 32'd9);
        chk("rex_next", 32'(req_ready), 32'b01);
        sb.push_back('{0, 32'd8});
        tick();
        req_valid = '0;
        wait_rsp(0, t);
        pop_check("rex_op");
        tick();

        run_op(1, OP_ALU_SRA, 32'h80000000, 32'd4, 32'hF8000000, "sra");
        tick();
        run_op(0, OP_ALU_NOP, 32'h0000FFFF, 32'd0, 32'hFFFF0000, "nop");
        tick();
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
